// File: rtl/button_event_arbiter.sv
// Serializes per-channel button event pulses onto one valid/ready stream via round-robin.
// Event eligible one cycle after its rising edge; output held stable until ev_ready, backlog saturates per channel.
module button_event_arbiter #(
    parameter int NUM_BTN = 5,
    parameter int CNT_W   = 2,
    parameter int ID_W    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] pulse,
    input  logic               ev_ready,
    output logic               ev_valid,
    output logic [ID_W-1:0]    ev_id,
    output logic [NUM_BTN-1:0] overflow,
    input  logic               ovf_clear,
    output logic               pending
);

    typedef enum logic {IDLE, PRESENT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_BTN - 1);

    state_t                          state_q, state_d;
    logic [NUM_BTN-1:0]              pulse_d_q;
    logic [NUM_BTN-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_BTN-1:0]              overflow_q, overflow_d;
    logic [ID_W-1:0]                 last_q, last_d;
    logic [ID_W-1:0]                 ev_id_q, ev_id_d;

    logic [NUM_BTN-1:0] nz;
    logic [ID_W-1:0]    winner;
    logic               found;
    logic               grant;
    logic [NUM_BTN-1:0] ovf_set;
    int                 idx;

    // Round-robin search over counters as registered at the start of the cycle.
    always_comb begin
        nz     = '0;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NUM_BTN; i++) begin
            nz[i] = (cnt_q[i] != '0);
        end
        for (int k = 1; k <= NUM_BTN; k++) begin
            idx = (int'(last_q) + k) % NUM_BTN;
            if (!found && nz[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ev_id_d = ev_id_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant   = 1'b1;
                    ev_id_d = winner;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ev_ready) begin
                    if (found) begin
                        grant   = 1'b1;
                        ev_id_d = winner;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        last_d = grant ? winner : last_q;
    end

    // Per-channel backlog: simultaneous event and grant cancel, saturation drops and flags.
    always_comb begin
        logic ev_i;
        logic gnt_i;
        cnt_d   = cnt_q;
        ovf_set = '0;
        ev_i    = 1'b0;
        gnt_i   = 1'b0;
        for (int i = 0; i < NUM_BTN; i++) begin
            ev_i  = pulse[i] & ~pulse_d_q[i];
            gnt_i = grant && (winner == ID_W'(i));
            if (ev_i && !gnt_i) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_set[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (!ev_i && gnt_i) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
        overflow_d = (overflow_q & ~{NUM_BTN{ovf_clear}}) | ovf_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pulse_d_q  <= '0;
            cnt_q      <= '0;
            overflow_q <= '0;
            last_q     <= LAST_RST;
            ev_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            pulse_d_q  <= pulse;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            last_q     <= last_d;
            ev_id_q    <= ev_id_d;
        end
    end

    assign ev_valid = (state_q == PRESENT);
    assign ev_id    = ev_id_q;
    assign overflow = overflow_q;
    assign pending  = |nz;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: single press, simultaneous, fairness, overflow, held level, reset.
module tb_button_event_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] pulse;
    logic       ev_ready;
    logic       ev_valid;
    logic [2:0] ev_id;
    logic [4:0] overflow;
    logic       ovf_clear;
    logic       pending;

    int total = 0;
    int bad   = 0;
    int hs;

    button_event_arbiter #(.NUM_BTN(5), .CNT_W(2), .ID_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .pulse     (pulse),
        .ev_ready  (ev_ready),
        .ev_valid  (ev_valid),
        .ev_id     (ev_id),
        .overflow  (overflow),
        .ovf_clear (ovf_clear),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        pulse     = '0;
        ev_ready  = 1'b0;
        ovf_clear = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Counts handshakes over n cycles with the current inputs held.
    task automatic count_hs(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (ev_valid && ev_ready) cnt++;
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pulse = '0; ev_ready = 1'b0; ovf_clear = 1'b0;
        #12;
        check("rst_valid", ev_valid, 0);
        check("rst_id", ev_id, 0);
        check("rst_ovf", overflow, 0);
        check("rst_pend", pending, 0);
        step();
        reset = 1'b0;

        // Single press on channel 2
        pulse = 5'b00100; ev_ready = 1'b1;
        step();
        pulse = '0;
        check("sp_valid_t", ev_valid, 0);
        check("sp_pend_t", pending, 1);
        step();
        check("sp_valid_t1", ev_valid, 1);
        check("sp_id_t1", ev_id, 2);
        check("sp_pend_t1", pending, 0);
        step();
        check("sp_valid_t2", ev_valid, 0);

        // Simultaneous edges on channels 0 and 3
        do_reset();
        pulse = 5'b01001; ev_ready = 1'b1;
        step();
        pulse = '0;
        step();
        check("sim_v1", ev_valid, 1);
        check("sim_id1", ev_id, 0);
        step();
        check("sim_v2", ev_valid, 1);
        check("sim_id2", ev_id, 3);
        step();
        check("sim_v3", ev_valid, 0);

        // Fairness: ch1 at slots 0,3,6; ch4 at slot 1
        do_reset();
        ev_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            pulse = '0;
            if (s == 0 || s == 3 || s == 6) pulse[1] = 1'b1;
            if (s == 1) pulse[4] = 1'b1;
            step();
            if (s == 1) check("fair_g1", ev_id, 1);
            if (s == 2) check("fair_g2", ev_id, 4);
            if (s == 2) check("fair_v2", ev_valid, 1);
            if (s == 3) check("fair_bubble", ev_valid, 0);
            if (s == 4) check("fair_g3", ev_id, 1);
            if (s == 4) check("fair_v3", ev_valid, 1);
        end
        pulse = '0;
        step(); step();

        // Backpressure and overflow on channel 1
        do_reset();
        ev_ready = 1'b0;
        for (int s = 0; s < 9; s++) begin
            pulse = (s % 2 == 0) ? 5'b00010 : 5'b00000;
            step();
            if (s == 1) check("bp_valid", ev_valid, 1);
            if (s == 1) check("bp_id", ev_id, 1);
            if (s == 7) check("bp_id_held", ev_id, 1);
            if (s == 7) check("bp_ovf_pre", overflow, 0);
            if (s == 7) check("bp_pend", pending, 1);
        end
        pulse = '0;
        check("bp_ovf_set", overflow, 5'b00010);
        check("bp_valid_held", ev_valid, 1);
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        check("bp_ovf_clr", overflow, 0);
        ev_ready = 1'b1;
        count_hs(10, hs);
        check("bp_drain_hs", hs, 4);
        check("bp_drain_idle", ev_valid, 0);

        // Held level on channel 0
        do_reset();
        ev_ready = 1'b1;
        pulse = 5'b00001;
        count_hs(20, hs);
        pulse = '0;
        begin
            int hs2;
            count_hs(5, hs2);
            check("held_one_event", hs + hs2, 1);
        end

        // Reset mid-operation with backlog
        do_reset();
        ev_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            pulse = (s % 2 == 0) ? 5'b00100 : 5'b00000;
            step();
        end
        pulse = '0;
        check("mr_valid_pre", ev_valid, 1);
        check("mr_pend_pre", pending, 1);
        reset = 1'b1;
        #1;
        check("mr_valid", ev_valid, 0);
        check("mr_pend", pending, 0);
        check("mr_id", ev_id, 0);
        step();
        reset = 1'b0;
        ev_ready = 1'b1;
        begin
            int vcnt = 0;
            for (int i = 0; i < 10; i++) begin
                if (ev_valid) vcnt++;
                step();
            end
            check("mr_no_events", vcnt, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
